// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use stall, branch flush and MUL/DIV freeze sequencing; HAZ_PERF_CNT_EN adds stall/flush counters
module hazard_stall_controller #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead_IDtoEX,
    input  logic [4:0]  writeReg_IDtoEX,
    input  logic [4:0]  readReg1,
    input  logic [4:0]  readReg2,
    input  logic        branchTaken_EX,
    input  logic        mdStart_EX,
    input  logic        mdDone,
    output logic        mdGo,
    output logic        stallPC,
    output logic        stallIFtoID,
    output logic        stallIDtoEX,
    output logic        flushIFtoID,
    output logic        flushIDtoEX,
    output logic        flushEXtoMEM,
    output logic        mdTimeout,
    output logic [31:0] stallCycles,
    output logic [31:0] flushCount
);
    typedef enum logic {RUN, MD_WAIT} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic to_flag, load_use, expire;
    // hazard priority in RUN; freeze until done or timeout in MD_WAIT
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        mdGo         = 1'b0;
        stallPC      = 1'b0;
        stallIFtoID  = 1'b0;
        stallIDtoEX  = 1'b0;
        flushIFtoID  = 1'b0;
        flushIDtoEX  = 1'b0;
        flushEXtoMEM = 1'b0;
        mdTimeout    = to_flag;
        load_use     = memRead_IDtoEX && writeReg_IDtoEX != 5'd0 &&
                       (writeReg_IDtoEX == readReg1 || writeReg_IDtoEX == readReg2);
        expire       = state == MD_WAIT && !mdDone && cnt == CNT_W'(MD_TIMEOUT - 1);
        if (state == RUN) begin
            if (mdStart_EX) begin
                mdGo         = 1'b1;
                stallPC      = 1'b1;
                stallIFtoID  = 1'b1;
                stallIDtoEX  = 1'b1;
                flushEXtoMEM = 1'b1;
                state_nxt    = MD_WAIT;
                cnt_nxt      = '0;
            end else if (branchTaken_EX) begin
                flushIFtoID = 1'b1;
                flushIDtoEX = 1'b1;
            end else if (load_use) begin
                stallPC     = 1'b1;
                stallIFtoID = 1'b1;
                flushIDtoEX = 1'b1;
            end
        end else if (mdDone || expire) begin
            state_nxt = RUN;
            mdTimeout = to_flag | expire;
        end else begin
            stallPC      = 1'b1;
            stallIFtoID  = 1'b1;
            stallIDtoEX  = 1'b1;
            flushEXtoMEM = 1'b1;
            cnt_nxt      = cnt + 1'b1;
        end
    end
    // state, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            cnt     <= '0;
            to_flag <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            to_flag <= to_flag | expire;
        end
    end
`ifdef HAZ_PERF_CNT_EN
    // performance counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            stallCycles <= stallCycles + {31'd0, stallPC};
            flushCount  <= flushCount + {31'd0, flushIFtoID | flushIDtoEX};
        end
    end
`else
    assign stallCycles = '0;
    assign flushCount  = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed checks of hazard stall/flush sequencing
module tb_hazard_stall_controller;
    logic clk = 1'b0, reset = 1'b1;
    logic memRead_IDtoEX = 1'b0, branchTaken_EX = 1'b0, mdStart_EX = 1'b0, mdDone = 1'b0;
    logic [4:0] writeReg_IDtoEX = 5'd0, readReg1 = 5'd0, readReg2 = 5'd0;
    logic mdGo, stallPC, stallIFtoID, stallIDtoEX, flushIFtoID, flushIDtoEX, flushEXtoMEM, mdTimeout;
    logic [31:0] stallCycles, flushCount;
    logic [6:0] ctl;
    int errors = 0, checks = 0;

    localparam logic [6:0] C_ZERO = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b0110010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_GO   = 7'b1111001;
    localparam logic [6:0] C_WAIT = 7'b0111001;

    hazard_stall_controller #(.MD_TIMEOUT(8), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .memRead_IDtoEX(memRead_IDtoEX),
        .writeReg_IDtoEX(writeReg_IDtoEX), .readReg1(readReg1), .readReg2(readReg2),
        .branchTaken_EX(branchTaken_EX), .mdStart_EX(mdStart_EX), .mdDone(mdDone),
        .mdGo(mdGo), .stallPC(stallPC), .stallIFtoID(stallIFtoID), .stallIDtoEX(stallIDtoEX),
        .flushIFtoID(flushIFtoID), .flushIDtoEX(flushIDtoEX), .flushEXtoMEM(flushEXtoMEM),
        .mdTimeout(mdTimeout), .stallCycles(stallCycles), .flushCount(flushCount)
    );

    always #5 clk = ~clk;
    assign ctl = {mdGo, stallPC, stallIFtoID, stallIDtoEX, flushIFtoID, flushIDtoEX, flushEXtoMEM};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memRead_IDtoEX = 0; branchTaken_EX = 0; mdStart_EX = 0; mdDone = 0;
        writeReg_IDtoEX = 0; readReg1 = 0; readReg2 = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_ZERO); end
        checks++; if (mdTimeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", mdTimeout); end
        checks++; if (stallCycles !== 32'd0) begin errors++; $display("FAIL reset_stallCycles got=%0d exp=0", stallCycles); end
        checks++; if (flushCount !== 32'd0) begin errors++; $display("FAIL reset_flushCount got=%0d exp=0", flushCount); end
    endtask

    task automatic test_load_use();
        memRead_IDtoEX = 1; writeReg_IDtoEX = 5; readReg1 = 3; readReg2 = 5; #1;
        checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU); end
        tick();
        memRead_IDtoEX = 0; #1;
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL lu_cleared got=%b exp=%b", ctl, C_ZERO); end
        memRead_IDtoEX = 1; writeReg_IDtoEX = 0; readReg1 = 0; readReg2 = 0; #1;
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL lu_x0 got=%b exp=%b", ctl, C_ZERO); end
        writeReg_IDtoEX = 7; readReg1 = 7; readReg2 = 2; #1;
        checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, C_LU); end
        memRead_IDtoEX = 0; #1;
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL lu_not_load got=%b exp=%b", ctl, C_ZERO); end
        memRead_IDtoEX = 1; readReg1 = 6; #1;
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL lu_no_match got=%b exp=%b", ctl, C_ZERO); end
        idle(); tick();
    endtask

    task automatic test_branch();
        memRead_IDtoEX = 1; writeReg_IDtoEX = 5; readReg2 = 5; branchTaken_EX = 1; #1;
        checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_over_lu got=%b exp=%b", ctl, C_BR); end
        idle(); mdDone = 1; #1;
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL done_in_run got=%b exp=%b", ctl, C_ZERO); end
        idle(); tick();
    endtask

    task automatic test_muldiv();
        mdStart_EX = 1; branchTaken_EX = 1; #1;
        checks++; if (ctl !== C_GO) begin errors++; $display("FAIL md_start got=%b exp=%b", ctl, C_GO); end
        tick();
        for (int i = 1; i < 4; i++) begin
            checks++; if (ctl !== C_WAIT) begin errors++; $display("FAIL md_wait%0d got=%b exp=%b", i, ctl, C_WAIT); end
            tick();
        end
        mdDone = 1; #1;
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL md_release got=%b exp=%b", ctl, C_ZERO); end
        tick();
        idle(); #1;
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL md_back_run got=%b exp=%b", ctl, C_ZERO); end
        branchTaken_EX = 1; #1;
        checks++; if (ctl !== C_BR) begin errors++; $display("FAIL md_run_branch got=%b exp=%b", ctl, C_BR); end
        checks++; if (mdTimeout !== 1'b0) begin errors++; $display("FAIL md_no_timeout got=%b exp=0", mdTimeout); end
        idle(); tick();
    endtask

    task automatic test_timeout();
        do_reset();
        mdStart_EX = 1; #1;
        checks++; if (ctl !== C_GO) begin errors++; $display("FAIL to_start got=%b exp=%b", ctl, C_GO); end
        tick();
        mdStart_EX = 0;
        for (int i = 1; i < 8; i++) begin
            #1;
            checks++; if (ctl !== C_WAIT || mdTimeout !== 1'b0) begin errors++; $display("FAIL to_wait%0d got=%b/%b exp=%b/0", i, ctl, mdTimeout, C_WAIT); end
            tick();
        end
        checks++; if (ctl !== C_ZERO || mdTimeout !== 1'b1) begin errors++; $display("FAIL to_expire got=%b/%b exp=%b/1", ctl, mdTimeout, C_ZERO); end
        tick(); tick(); tick();
        checks++; if (ctl !== C_ZERO || mdTimeout !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b/%b exp=%b/1", ctl, mdTimeout, C_ZERO); end
        do_reset();
        checks++; if (mdTimeout !== 1'b0) begin errors++; $display("FAIL to_cleared got=%b exp=0", mdTimeout); end
    endtask

    task automatic test_reset_mid_wait();
        mdStart_EX = 1; tick();
        mdStart_EX = 0; tick();
        #1;
        checks++; if (ctl !== C_WAIT) begin errors++; $display("FAIL rmw_in_wait got=%b exp=%b", ctl, C_WAIT); end
        reset = 1; tick(); reset = 0; #1;
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL rmw_run got=%b exp=%b", ctl, C_ZERO); end
        mdStart_EX = 1; #1;
        checks++; if (ctl !== C_GO) begin errors++; $display("FAIL rmw_fresh_go got=%b exp=%b", ctl, C_GO); end
        tick();
        mdStart_EX = 0; mdDone = 1; #1;
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL rmw_release got=%b exp=%b", ctl, C_ZERO); end
        idle(); tick();
    endtask

    task automatic test_perf();
        logic [31:0] exp_s, exp_f;
        do_reset();
        memRead_IDtoEX = 1; writeReg_IDtoEX = 9; readReg1 = 9; tick();
        idle(); branchTaken_EX = 1; tick();
        idle(); mdStart_EX = 1; tick();
        mdStart_EX = 0; tick(); tick(); tick();
        mdDone = 1; tick();
        idle(); tick();
`ifdef HAZ_PERF_CNT_EN
        exp_s = 32'd5; exp_f = 32'd2;
`else
        exp_s = 32'd0; exp_f = 32'd0;
`endif
        checks++; if (stallCycles !== exp_s) begin errors++; $display("FAIL perf_stallCycles got=%0d exp=%0d", stallCycles, exp_s); end
        checks++; if (flushCount !== exp_f) begin errors++; $display("FAIL perf_flushCount got=%0d exp=%0d", flushCount, exp_f); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_timeout();
        test_reset_mid_wait();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
